// File: rtl/prog_loader_ctrl.sv
// Boot-time instruction RAM loader: receives a framed UART byte stream, writes
// the payload from byte address 0, and keeps the CPU in reset until a load checks out.
module prog_loader_ctrl #(
  parameter int  MEM_SIZE    = 1024,
  parameter int  TIMEOUT_CYC = 100000,
  localparam int ADDRW       = $clog2(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic [ADDRW-1:0] cpu_addr,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [7:0]       ram_din,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_LEN_LO = 3'd2,
    S_LEN_HI = 3'd3,
    S_DATA   = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t           state, state_d;
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] wr_addr;
  logic [7:0]       len_lo;
  logic [15:0]      cnt;
  logic [7:0]       sum;
  logic [TW-1:0]    tmo;
  logic             xfer;
  logic             session_start;
  logic             err_enter;
  logic [1:0]       code_d;
  logic [15:0]      n_len;

  // Handshake: a byte moves on any cycle where rx_valid and rx_ready are both
  // high; rx_valid never waits on rx_ready and rx_ready depends only on state.
  assign busy          = (state == S_SYNC) || (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA) || (state == S_CSUM);
  assign rx_ready      = busy;
  assign xfer          = rx_valid & rx_ready;
  assign done          = (state == S_DONE);
  assign session_start = start && ((state == S_IDLE) || (state == S_ERR));
  assign n_len         = {rx_data, len_lo};
  assign ram_addr      = busy ? wr_addr : cpu_addr;
  assign dbg_state     = state;

  always_comb begin
    state_d = state;
    code_d  = 2'd0;
    unique case (state)
      S_IDLE, S_ERR: if (start) state_d = S_SYNC;
      S_SYNC: begin
        if (xfer) begin
          if (rx_data == 8'hA5) begin
            state_d = S_LEN_LO;
          end else begin
            state_d = S_ERR;
            code_d  = 2'd1;
          end
        end
      end
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if ((n_len == 16'd0) || ({1'b0, n_len} > 17'(MEM_SIZE))) begin
            state_d = S_ERR;
            code_d  = 2'd2;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: if (xfer && (cnt == 16'd1)) state_d = S_CSUM;
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == sum) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            code_d  = 2'd3;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A stalled stream overrides whatever the current state would do.
    if (busy && !xfer && (tmo == TW'(TIMEOUT_CYC - 1))) begin
      state_d = S_ERR;
      code_d  = 2'd0;
    end
  end

  assign err_enter = (state_d == S_ERR) && (state != S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      wr_addr   <= '0;
      len_lo    <= 8'd0;
      cnt       <= 16'd0;
      sum       <= 8'd0;
      tmo       <= '0;
      ram_we    <= 1'b0;
      ram_din   <= 8'd0;
      cpu_rst_n <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state  <= state_d;
      ram_we <= 1'b0;
      if (session_start) begin
        wr_ptr    <= '0;
        wr_addr   <= '0;
        sum       <= 8'd0;
        tmo       <= '0;
        err       <= 1'b0;
        err_code  <= 2'd0;
        cpu_rst_n <= 1'b0;
      end else begin
        if (xfer || !busy) tmo <= '0;
        else               tmo <= tmo + TW'(1);
        if (err_enter) begin
          err      <= 1'b1;
          err_code <= code_d;
        end
        if (state == S_DONE) cpu_rst_n <= 1'b1;
        if (xfer) begin
          case (state)
            S_LEN_LO: len_lo <= rx_data;
            S_LEN_HI: cnt    <= n_len;
            S_DATA: begin
              ram_we  <= 1'b1;
              ram_din <= rx_data;
              wr_addr <= wr_ptr;
              wr_ptr  <= wr_ptr + ADDRW'(1);
              sum     <= sum + rx_data;
              cnt     <= cnt - 16'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
